// File: rtl/control_sequencer.sv
// control_sequencer: hardwired T-state control unit for the single-bus RISC datapath.
// Optional feature: define CU_MULDIV_EN to enable the 7-cycle mul/div sequences.
module control_sequencer #(
  parameter int OPW = 5
) (
  input  logic        Clock,
  input  logic        Reset,
  input  logic [31:0] IR,
  input  logic        CON_FF,
  input  logic        Stop,
  output logic        Run,
  output logic        PCout,
  output logic        Zhighout,
  output logic        Zlowout,
  output logic        MDRout,
  output logic        HIout,
  output logic        LOout,
  output logic        InPortout,
  output logic        Cout,
  output logic        BAout,
  output logic        Rout,
  output logic        PCin,
  output logic        MARin,
  output logic        MDRin,
  output logic        IRin,
  output logic        Yin,
  output logic        Zin,
  output logic        HIin,
  output logic        LOin,
  output logic        OutPortin,
  output logic        CONin,
  output logic        Rin,
  output logic        Gra,
  output logic        Grb,
  output logic        Grc,
  output logic        IncPC,
  output logic        Read,
  output logic        Write
);

  typedef enum logic [3:0] {
    S_RST  = 4'd0,
    S_T0   = 4'd1,
    S_T1   = 4'd2,
    S_T2   = 4'd3,
    S_T3   = 4'd4,
    S_T4   = 4'd5,
    S_T5   = 4'd6,
    S_T6   = 4'd7,
    S_T7   = 4'd8,
    S_HALT = 4'd9
  } state_t;

  localparam logic [OPW-1:0] OP_LD    = OPW'(5'b00000);
  localparam logic [OPW-1:0] OP_LDI   = OPW'(5'b00001);
  localparam logic [OPW-1:0] OP_ST    = OPW'(5'b00010);
  localparam logic [OPW-1:0] OP_ADD   = OPW'(5'b00011);
  localparam logic [OPW-1:0] OP_ROL   = OPW'(5'b01010);
  localparam logic [OPW-1:0] OP_ADDI  = OPW'(5'b01011);
  localparam logic [OPW-1:0] OP_ORI   = OPW'(5'b01101);
  localparam logic [OPW-1:0] OP_MUL   = OPW'(5'b01110);
  localparam logic [OPW-1:0] OP_DIV   = OPW'(5'b01111);
  localparam logic [OPW-1:0] OP_NEG   = OPW'(5'b10000);
  localparam logic [OPW-1:0] OP_NOT   = OPW'(5'b10001);
  localparam logic [OPW-1:0] OP_BR    = OPW'(5'b10010);
  localparam logic [OPW-1:0] OP_JR    = OPW'(5'b10011);
  localparam logic [OPW-1:0] OP_IN    = OPW'(5'b10101);
  localparam logic [OPW-1:0] OP_OUT   = OPW'(5'b10110);
  localparam logic [OPW-1:0] OP_MFHI  = OPW'(5'b10111);
  localparam logic [OPW-1:0] OP_MFLO  = OPW'(5'b11000);
  localparam logic [OPW-1:0] OP_HALT  = OPW'(5'b11010);

  state_t         r_state;
  state_t         w_next;
  state_t         w_last;
  logic [OPW-1:0] w_op;
  logic           w_unused_ir;

  logic w_ld, w_ldi, w_st, w_rt, w_imm, w_md, w_neg, w_br;
  logic w_jr, w_in, w_out, w_mfhi, w_mflo, w_halt;

  assign w_op        = IR[31 -: OPW];
  assign w_unused_ir = ^IR[31-OPW:0];

  // Instruction class decode
  assign w_ld   = (w_op == OP_LD);
  assign w_ldi  = (w_op == OP_LDI);
  assign w_st   = (w_op == OP_ST);
  assign w_rt   = (w_op >= OP_ADD) && (w_op <= OP_ROL);
  assign w_imm  = (w_op >= OP_ADDI) && (w_op <= OP_ORI);
`ifdef CU_MULDIV_EN
  assign w_md   = (w_op == OP_MUL) || (w_op == OP_DIV);
`else
  assign w_md   = 1'b0;
`endif
  assign w_neg  = (w_op == OP_NEG) || (w_op == OP_NOT);
  assign w_br   = (w_op == OP_BR);
  assign w_jr   = (w_op == OP_JR);
  assign w_in   = (w_op == OP_IN);
  assign w_out  = (w_op == OP_OUT);
  assign w_mfhi = (w_op == OP_MFHI);
  assign w_mflo = (w_op == OP_MFLO);
  assign w_halt = (w_op == OP_HALT);

  // Final T-state of the current instruction; unlisted opcodes end after fetch
  always_comb begin
    w_last = S_T2;
    if (w_ld || w_st)
      w_last = S_T7;
    else if (w_md || w_br)
      w_last = S_T6;
    else if (w_ldi || w_rt || w_imm)
      w_last = S_T5;
    else if (w_neg)
      w_last = S_T4;
    else if (w_jr || w_in || w_out || w_mfhi || w_mflo)
      w_last = S_T3;
  end

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset)
      r_state <= S_RST;
    else
      r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_RST:   w_next = S_T0;
      S_HALT:  w_next = S_HALT;
      default: begin
        if ((r_state == S_T2) && w_halt)
          w_next = S_HALT;
        else if (r_state == w_last)
          w_next = Stop ? S_HALT : S_T0;
        else
          w_next = state_t'(r_state + 4'd1);
      end
    endcase
  end

  assign Run = (r_state != S_RST) && (r_state != S_HALT);

  always_comb begin
    PCout     = 1'b0;
    Zhighout  = 1'b0;
    Zlowout   = 1'b0;
    MDRout    = 1'b0;
    HIout     = 1'b0;
    LOout     = 1'b0;
    InPortout = 1'b0;
    Cout      = 1'b0;
    BAout     = 1'b0;
    Rout      = 1'b0;
    PCin      = 1'b0;
    MARin     = 1'b0;
    MDRin     = 1'b0;
    IRin      = 1'b0;
    Yin       = 1'b0;
    Zin       = 1'b0;
    HIin      = 1'b0;
    LOin      = 1'b0;
    OutPortin = 1'b0;
    CONin     = 1'b0;
    Rin       = 1'b0;
    Gra       = 1'b0;
    Grb       = 1'b0;
    Grc       = 1'b0;
    IncPC     = 1'b0;
    Read      = 1'b0;
    Write     = 1'b0;
    case (r_state)
      S_T0: begin
        PCout = 1'b1;
        MARin = 1'b1;
        IncPC = 1'b1;
        PCin  = 1'b1;
      end
      S_T1: begin
        Read  = 1'b1;
        MDRin = 1'b1;
      end
      S_T2: begin
        MDRout = 1'b1;
        IRin   = 1'b1;
      end
      S_T3: begin
        if (w_ld || w_ldi || w_st) begin
          Grb = 1'b1; BAout = 1'b1; Yin = 1'b1;
        end else if (w_rt || w_imm) begin
          Grb = 1'b1; Rout = 1'b1; Yin = 1'b1;
        end else if (w_md) begin
          Gra = 1'b1; Rout = 1'b1; Yin = 1'b1;
        end else if (w_neg) begin
          Grb = 1'b1; Rout = 1'b1; Zin = 1'b1;
        end else if (w_br) begin
          Gra = 1'b1; Rout = 1'b1; CONin = 1'b1;
        end else if (w_jr) begin
          Gra = 1'b1; Rout = 1'b1; PCin = 1'b1;
        end else if (w_in) begin
          InPortout = 1'b1; Gra = 1'b1; Rin = 1'b1;
        end else if (w_out) begin
          Gra = 1'b1; Rout = 1'b1; OutPortin = 1'b1;
        end else if (w_mfhi) begin
          HIout = 1'b1; Gra = 1'b1; Rin = 1'b1;
        end else if (w_mflo) begin
          LOout = 1'b1; Gra = 1'b1; Rin = 1'b1;
        end
      end
      S_T4: begin
        if (w_ld || w_ldi || w_st || w_imm) begin
          Cout = 1'b1; Zin = 1'b1;
        end else if (w_rt) begin
          Grc = 1'b1; Rout = 1'b1; Zin = 1'b1;
        end else if (w_md) begin
          Grb = 1'b1; Rout = 1'b1; Zin = 1'b1;
        end else if (w_neg) begin
          Zlowout = 1'b1; Gra = 1'b1; Rin = 1'b1;
        end else if (w_br) begin
          PCout = 1'b1; Yin = 1'b1;
        end
      end
      S_T5: begin
        if (w_ld || w_st) begin
          Zlowout = 1'b1; MARin = 1'b1;
        end else if (w_ldi || w_rt || w_imm) begin
          Zlowout = 1'b1; Gra = 1'b1; Rin = 1'b1;
        end else if (w_md) begin
          Zlowout = 1'b1; LOin = 1'b1;
        end else if (w_br) begin
          Cout = 1'b1; Zin = 1'b1;
        end
      end
      S_T6: begin
        if (w_ld) begin
          Read = 1'b1; MDRin = 1'b1;
        end else if (w_st) begin
          Gra = 1'b1; Rout = 1'b1; MDRin = 1'b1;
        end else if (w_md) begin
          Zhighout = 1'b1; HIin = 1'b1;
        end else if (w_br && CON_FF) begin
          Zlowout = 1'b1; PCin = 1'b1;
        end
      end
      S_T7: begin
        if (w_ld) begin
          MDRout = 1'b1; Gra = 1'b1; Rin = 1'b1;
        end else if (w_st) begin
          Write = 1'b1;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_control_sequencer.sv
// Randomized bench for control_sequencer against a table-driven model of the instruction set.
`timescale 1ns/1ps
module tb_control_sequencer;

  typedef logic [26:0] cw_t;
  localparam cw_t C_PCout     = 27'd1 << 0;
  localparam cw_t C_Zhighout  = 27'd1 << 1;
  localparam cw_t C_Zlowout   = 27'd1 << 2;
  localparam cw_t C_MDRout    = 27'd1 << 3;
  localparam cw_t C_HIout     = 27'd1 << 4;
  localparam cw_t C_LOout     = 27'd1 << 5;
  localparam cw_t C_InPortout = 27'd1 << 6;
  localparam cw_t C_Cout      = 27'd1 << 7;
  localparam cw_t C_BAout     = 27'd1 << 8;
  localparam cw_t C_Rout      = 27'd1 << 9;
  localparam cw_t C_PCin      = 27'd1 << 10;
  localparam cw_t C_MARin     = 27'd1 << 11;
  localparam cw_t C_MDRin     = 27'd1 << 12;
  localparam cw_t C_IRin      = 27'd1 << 13;
  localparam cw_t C_Yin       = 27'd1 << 14;
  localparam cw_t C_Zin       = 27'd1 << 15;
  localparam cw_t C_HIin      = 27'd1 << 16;
  localparam cw_t C_LOin      = 27'd1 << 17;
  localparam cw_t C_OutPortin = 27'd1 << 18;
  localparam cw_t C_CONin     = 27'd1 << 19;
  localparam cw_t C_Rin       = 27'd1 << 20;
  localparam cw_t C_Gra       = 27'd1 << 21;
  localparam cw_t C_Grb       = 27'd1 << 22;
  localparam cw_t C_Grc       = 27'd1 << 23;
  localparam cw_t C_IncPC     = 27'd1 << 24;
  localparam cw_t C_Read      = 27'd1 << 25;
  localparam cw_t C_Write     = 27'd1 << 26;

  localparam cw_t F0 = C_PCout | C_MARin | C_IncPC | C_PCin;
  localparam cw_t F1 = C_Read | C_MDRin;
  localparam cw_t F2 = C_MDRout | C_IRin;

  localparam int OP_BR   = 18;
  localparam int OP_HALT = 26;

  logic        Clock = 1'b0;
  logic        Reset = 1'b1;
  logic [31:0] IR = '0;
  logic        CON_FF = 1'b0;
  logic        Stop = 1'b0;
  logic        Run;
  logic PCout, Zhighout, Zlowout, MDRout, HIout, LOout, InPortout, Cout, BAout, Rout;
  logic PCin, MARin, MDRin, IRin, Yin, Zin, HIin, LOin, OutPortin, CONin, Rin;
  logic Gra, Grb, Grc, IncPC, Read, Write;
  cw_t  dut_cw;

  control_sequencer #(.OPW(5)) u_dut (
    .Clock(Clock), .Reset(Reset), .IR(IR), .CON_FF(CON_FF), .Stop(Stop), .Run(Run),
    .PCout(PCout), .Zhighout(Zhighout), .Zlowout(Zlowout), .MDRout(MDRout),
    .HIout(HIout), .LOout(LOout), .InPortout(InPortout), .Cout(Cout),
    .BAout(BAout), .Rout(Rout), .PCin(PCin), .MARin(MARin), .MDRin(MDRin),
    .IRin(IRin), .Yin(Yin), .Zin(Zin), .HIin(HIin), .LOin(LOin),
    .OutPortin(OutPortin), .CONin(CONin), .Rin(Rin), .Gra(Gra), .Grb(Grb),
    .Grc(Grc), .IncPC(IncPC), .Read(Read), .Write(Write)
  );

  assign dut_cw = {Write, Read, IncPC, Grc, Grb, Gra, Rin, CONin, OutPortin, LOin, HIin,
                   Zin, Yin, IRin, MDRin, MARin, PCin, Rout, BAout, Cout, InPortout,
                   LOout, HIout, MDRout, Zlowout, Zhighout, PCout};

  always #5 Clock = ~Clock;

  int   total = 0;
  int   bad = 0;
  logic chk_en = 1'b0;

  // Model: per-opcode list of control words, one per T-state, plus instruction length
  cw_t         prog [32][8];
  int unsigned plen [32];

  typedef enum {M_RST, M_RUN, M_HALT} mmode_t;
  mmode_t      m_mode = M_RST;
  int unsigned m_step = 0;

  task automatic def(input int op, input int unsigned len,
                     input cw_t s3, input cw_t s4, input cw_t s5, input cw_t s6, input cw_t s7);
    prog[op][0] = F0; prog[op][1] = F1; prog[op][2] = F2;
    prog[op][3] = s3; prog[op][4] = s4; prog[op][5] = s5;
    prog[op][6] = s6; prog[op][7] = s7;
    plen[op] = len;
  endtask

  task automatic build();
    cw_t ba, cz, wr;
    ba = C_Grb | C_BAout | C_Yin;
    cz = C_Cout | C_Zin;
    wr = C_Zlowout | C_Gra | C_Rin;
    for (int op = 0; op < 32; op++) def(op, 3, '0, '0, '0, '0, '0);
    def(0, 8, ba, cz, C_Zlowout | C_MARin, C_Read | C_MDRin, C_MDRout | C_Gra | C_Rin);
    def(1, 6, ba, cz, wr, '0, '0);
    def(2, 8, ba, cz, C_Zlowout | C_MARin, C_Gra | C_Rout | C_MDRin, C_Write);
    for (int op = 3; op <= 10; op++)
      def(op, 6, C_Grb | C_Rout | C_Yin, C_Grc | C_Rout | C_Zin, wr, '0, '0);
    for (int op = 11; op <= 13; op++)
      def(op, 6, C_Grb | C_Rout | C_Yin, cz, wr, '0, '0);
`ifdef CU_MULDIV_EN
    for (int op = 14; op <= 15; op++)
      def(op, 7, C_Gra | C_Rout | C_Yin, C_Grb | C_Rout | C_Zin,
          C_Zlowout | C_LOin, C_Zhighout | C_HIin, '0);
`endif
    for (int op = 16; op <= 17; op++)
      def(op, 5, C_Grb | C_Rout | C_Zin, wr, '0, '0, '0);
    def(OP_BR, 7, C_Gra | C_Rout | C_CONin, C_PCout | C_Yin, cz, '0, '0);
    def(19, 4, C_Gra | C_Rout | C_PCin, '0, '0, '0, '0);
    def(21, 4, C_InPortout | C_Gra | C_Rin, '0, '0, '0, '0);
    def(22, 4, C_Gra | C_Rout | C_OutPortin, '0, '0, '0, '0);
    def(23, 4, C_HIout | C_Gra | C_Rin, '0, '0, '0, '0);
    def(24, 4, C_LOout | C_Gra | C_Rin, '0, '0, '0, '0);
  endtask

  function automatic cw_t model_cw(input int op, input int unsigned st, input logic con);
    if (op == OP_BR && st == 6 && con) return C_Zlowout | C_PCin;
    return prog[op][st];
  endfunction

  always @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      m_mode = M_RST;
    end else begin
      case (m_mode)
        M_RST: begin m_mode = M_RUN; m_step = 0; end
        M_RUN: begin
          if (m_step == plen[int'(IR[31:27])] - 1) begin
            if (int'(IR[31:27]) == OP_HALT || Stop) m_mode = M_HALT;
            else m_step = 0;
          end else begin
            m_step = m_step + 1;
          end
        end
        default: ;
      endcase
    end
  end

  always @(negedge Clock) begin : compare
    cw_t  e;
    logic er;
    if (chk_en) begin
      er = (m_mode == M_RUN);
      e  = er ? model_cw(int'(IR[31:27]), m_step, CON_FF) : '0;
      total++;
      if (Run !== er) begin
        bad++;
        $display("FAIL run t=%0t step=%0d op=%0d: got %b want %b", $time, m_step, IR[31:27], Run, er);
      end
      total++;
      if (dut_cw !== e) begin
        bad++;
        $display("FAIL cw t=%0t step=%0d op=%0d: got %h want %h", $time, m_step, IR[31:27], dut_cw, e);
      end
    end
  end

  task automatic lit(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic cycle();
    @(posedge Clock);
    #2;
  endtask

  cw_t cap [8];

  // Called at posedge+2 of T0; returns at posedge+2 of the following state
  task automatic exec(input logic [31:0] ir, input logic con, input logic stp,
                      input int L, input string nm);
    IR = ir;
    CON_FF = con;
    for (int k = 0; k < L; k++) begin
      if (k == L - 1) Stop = stp;
      @(negedge Clock);
      cap[k] = dut_cw;
      cycle();
    end
    Stop = 1'b0;
    if (stp) begin
      lit({nm, "_halt_run"}, 32'(Run), 32'd0);
      lit({nm, "_halt_cw"}, 32'(dut_cw), 32'd0);
    end else begin
      lit({nm, "_next_T0"}, 32'(dut_cw), 32'(F0));
    end
  endtask

  task automatic reset_pulse();
    Reset = 1'b0;
    cycle();
    Reset = 1'b1;
  endtask

  initial begin
    int wc;
    int runs;
    int hcnt;
    int op;
    build();
    #1 Reset = 1'b0;
    #1 chk_en = 1'b1;
    repeat (2) @(posedge Clock);
    #2;
    lit("rst_run", 32'(Run), 32'd0);
    lit("rst_cw", 32'(dut_cw), 32'd0);
    Reset = 1'b1;
    cycle();

    exec(32'h08800005, 1'b0, 1'b0, 6, "ldi");
    lit("ldi_T3", 32'(cap[3]), 32'(C_Grb | C_BAout | C_Yin));
    lit("ldi_T5", 32'(cap[5]), 32'(C_Zlowout | C_Gra | C_Rin));

    exec(32'h10000000, 1'b0, 1'b0, 8, "st");
    wc = 0;
    for (int k = 0; k < 7; k++) if (cap[k][26]) wc++;
    lit("st_early_write", 32'(wc), 32'd0);
    lit("st_T6", 32'(cap[6]), 32'(C_Gra | C_Rout | C_MDRin));
    lit("st_T7", 32'(cap[7]), 32'(C_Write));

    exec(32'h90000000, 1'b0, 1'b0, 7, "br0");
    lit("br0_T6", 32'(cap[6]), 32'd0);
    exec(32'h90000000, 1'b1, 1'b0, 7, "br1");
    lit("br1_T6", 32'(cap[6]), 32'(C_Zlowout | C_PCin));
    CON_FF = 1'b0;

`ifdef CU_MULDIV_EN
    exec(32'h70000000, 1'b0, 1'b0, 7, "mul");
    lit("mul_T5", 32'(cap[5]), 32'(C_Zlowout | C_LOin));
    lit("mul_T6", 32'(cap[6]), 32'(C_Zhighout | C_HIin));
`else
    exec(32'h70000000, 1'b0, 1'b0, 3, "mul");
    lit("mul_nohilo", 32'((cap[0] | cap[1] | cap[2]) & (C_HIin | C_LOin)), 32'd0);
`endif

    // Asynchronous reset in ld T5
    IR = 32'h00000000;
    for (int k = 0; k < 5; k++) cycle();
    lit("ld_T5", 32'(dut_cw), 32'(C_Zlowout | C_MARin));
    #1 Reset = 1'b0;
    #1;
    lit("async_rst_cw", 32'(dut_cw), 32'd0);
    lit("async_rst_run", 32'(Run), 32'd0);
    cycle();
    Reset = 1'b1;
    cycle();
    lit("restart_T0", 32'(dut_cw), 32'(F0));

    exec(32'h18000000, 1'b0, 1'b1, 6, "add_stop");
    runs = 0;
    for (int k = 0; k < 20; k++) begin
      cycle();
      if (Run !== 1'b0 || dut_cw !== '0) runs++;
    end
    lit("halt_hold", 32'(runs), 32'd0);
    reset_pulse();
    cycle();
    lit("halt_reset_T0", 32'(dut_cw), 32'(F0));

    hcnt = 0;
    for (int c = 0; c < 8000; c++) begin
      if (m_mode == M_RUN && m_step == 0) begin
        op = int'($urandom_range(0, 31));
        if (op == OP_HALT && $urandom_range(0, 3) != 0) op = 25;
        IR = {5'(op), 27'($urandom)};
      end
      CON_FF = 1'($urandom_range(0, 1));
      Stop = ($urandom_range(0, 15) == 0);
      if (m_mode == M_HALT) begin
        hcnt++;
        if (hcnt > 3) begin
          hcnt = 0;
          reset_pulse();
        end
      end else if ($urandom_range(0, 299) == 0) begin
        reset_pulse();
      end
      cycle();
    end

    chk_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
